// File: rtl/ps2_key_queue.sv
// ps2_key_queue
//   Turns the PS/2 receiver byte stream into key events {ext, brk, code},
//   drops keyboard housekeeping bytes, queues events in a small FIFO and
//   exposes them to the Z80 through a status/control and a key-code register.
//
// Ports
//   cpuclk     system clock
//   rst        synchronous, active-high reset
//   data       CPU data bus (driven only during a valid register read)
//   ncs        active-low chip select
//   nrd        active-low read strobe
//   nwr        active-low write strobe
//   addr       I/O sub-address
//   rx_byte    byte from the PS/2 receiver
//   rx_strobe  one-cycle pulse, rx_byte valid in the same cycle
//   intr_out   level interrupt, high while the FIFO holds events
//
// Status register: [7] head ext, [6] head brk, [5] ovf, [4] full, [3:0] count.
// Writing STATUS with data[5]=1 clears ovf.
module ps2_key_queue #(
    parameter int         DEPTH          = 8,
    parameter int         PREFIX_TIMEOUT = 40000,
    parameter logic [3:0] STATUS_ADDR    = 4'd6,
    parameter logic [3:0] DATA_ADDR      = 4'd7
) (
    input  logic       cpuclk,
    input  logic       rst,
    inout  wire  [7:0] data,
    input  logic       ncs,
    input  logic       nrd,
    input  logic       nwr,
    input  logic [3:0] addr,
    input  logic [7:0] rx_byte,
    input  logic       rx_strobe,
    output logic       intr_out
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(PREFIX_TIMEOUT + 1);

    localparam logic [TW-1:0] TMO_LOAD = TW'(PREFIX_TIMEOUT);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_E0,
        S_F0,
        S_E0F0
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tmo;
    logic          push, push_ext, push_brk;

    logic [9:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          ovf;
    logic          got_rd;

    logic          empty, full;
    logic          rd_data_v, rd_stat_v, wr_stat_v;
    logic          pop, push_ok, drop;
    logic [9:0]    head;
    logic [7:0]    status, rd_mux;
    logic          unused_data;

    // Self-test / ack / echo / resend / error bytes carry no key information.
    function automatic logic is_housekeeping(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
               (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    // ---------------- prefix decoder ----------------
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_ext  = 1'b0;
        push_brk  = 1'b0;
        if (rx_strobe) begin
            case (state)
                S_IDLE: begin
                    if (rx_byte == 8'hE0)               state_nxt = S_E0;
                    else if (rx_byte == 8'hF0)          state_nxt = S_F0;
                    else if (!is_housekeeping(rx_byte)) push = 1'b1;
                end
                S_E0: begin
                    if (rx_byte == 8'hF0)      state_nxt = S_E0F0;
                    else if (rx_byte != 8'hE0) begin
                        push      = 1'b1;
                        push_ext  = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                S_F0: begin
                    push      = 1'b1;
                    push_brk  = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: begin
                    push      = 1'b1;
                    push_ext  = 1'b1;
                    push_brk  = 1'b1;
                    state_nxt = S_IDLE;
                end
            endcase
        end else if (state != S_IDLE && tmo == '0) begin
            // A stalled prefix is abandoned without producing an event.
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge cpuclk) begin
        if (rst) begin
            state <= S_IDLE;
            tmo   <= '0;
        end else begin
            state <= state_nxt;
            if (rx_strobe && state_nxt != S_IDLE) tmo <= TMO_LOAD;
            else if (state_nxt == S_IDLE)         tmo <= '0;
            else if (tmo != '0)                   tmo <= tmo - TMO_ONE;
        end
    end

    // ---------------- CPU register decode ----------------
    assign rd_data_v = !ncs && !nrd && (addr == DATA_ADDR);
    assign rd_stat_v = !ncs && !nrd && (addr == STATUS_ADDR);
    assign wr_stat_v = !ncs && !nwr && (addr == STATUS_ADDR);

    // ---------------- FIFO ----------------
    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    // got_rd is the previous cycle's DATA-read state, so a pop fires once on
    // the falling edge of the read however long the strobe was held.
    assign pop     = got_rd && !rd_data_v && !empty;
    // A pop in the same cycle frees the slot for the incoming event.
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge cpuclk) begin
        if (!rst && push_ok) mem[wr_ptr] <= {push_ext, push_brk, rx_byte};
    end

    always_ff @(posedge cpuclk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            got_rd <= 1'b0;
        end else begin
            got_rd <= rd_data_v;
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
            // Set takes priority over a simultaneous clear.
            if (drop)                      ovf <= 1'b1;
            else if (wr_stat_v && data[5]) ovf <= 1'b0;
        end
    end

    // ---------------- read path (combinational) ----------------
    assign head   = empty ? 10'd0 : mem[rd_ptr];
    assign status = {head[9], head[8], ovf, full, 4'(count)};
    assign rd_mux = rd_stat_v ? status : head[7:0];
    assign data   = (rd_stat_v || rd_data_v) ? rd_mux : 8'hzz;

    assign intr_out = !empty;

    assign unused_data = ^{data[7:6], data[4:0]};

endmodule

// File: tb/tb_ps2_key_queue.sv
module tb_ps2_key_queue;

    localparam int         DEPTH = 8;
    localparam int         T     = 20;
    localparam logic [3:0] SA    = 4'd6;
    localparam logic [3:0] DA    = 4'd7;

    logic       cpuclk = 1'b0;
    logic       rst    = 1'b1;
    logic       ncs    = 1'b1;
    logic       nrd    = 1'b1;
    logic       nwr    = 1'b1;
    logic [3:0] addr   = 4'd0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_strobe = 1'b0;
    logic       intr_out;
    wire  [7:0] data;
    logic       tb_drive = 1'b0;
    logic [7:0] tb_dout  = 8'h00;

    assign data = tb_drive ? tb_dout : 8'hzz;

    int checks   = 0;
    int failures = 0;

    ps2_key_queue #(
        .DEPTH(DEPTH), .PREFIX_TIMEOUT(T), .STATUS_ADDR(SA), .DATA_ADDR(DA)
    ) dut (
        .cpuclk(cpuclk), .rst(rst), .data(data), .ncs(ncs), .nrd(nrd),
        .nwr(nwr), .addr(addr), .rx_byte(rx_byte), .rx_strobe(rx_strobe),
        .intr_out(intr_out)
    );

    always #5 cpuclk = ~cpuclk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge cpuclk);
        rst = 1'b1; ncs = 1'b1; nrd = 1'b1; nwr = 1'b1; rx_strobe = 1'b0; tb_drive = 1'b0;
        @(negedge cpuclk);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge cpuclk);
        rx_byte = b; rx_strobe = 1'b1;
        @(negedge cpuclk);
        rx_strobe = 1'b0;
    endtask

    // Read one register; returns one cycle after the strobe is released.
    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        @(negedge cpuclk);
        ncs = 1'b0; nrd = 1'b0; addr = a;
        #1 v = data;
        @(negedge cpuclk);
        ncs = 1'b1; nrd = 1'b1;
        @(negedge cpuclk);
    endtask

    task automatic wr_status(input logic [7:0] v);
        @(negedge cpuclk);
        ncs = 1'b0; nwr = 1'b0; addr = SA; tb_drive = 1'b1; tb_dout = v;
        @(negedge cpuclk);
        ncs = 1'b1; nwr = 1'b1; tb_drive = 1'b0;
    endtask

    // The bench drives 0x00 onto the bus; any DUT driver shows up as a
    // non-zero or unknown value.
    task automatic chk_hiz(input string nm, input logic [3:0] a, input logic rd_lo);
        logic [7:0] v;
        @(negedge cpuclk);
        ncs = 1'b0; nrd = !rd_lo; addr = a; tb_drive = 1'b1; tb_dout = 8'h00;
        #1 v = data;
        chk(nm, v, 8'h00);
        @(negedge cpuclk);
        ncs = 1'b1; nrd = 1'b1; tb_drive = 1'b0;
    endtask

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         n;
        logic [7:0] exp_stat;
        logic [7:0] exp_code;
    } vec_t;

    vec_t vecs[12];

    // ---------------- random-test reference model ----------------
    logic [9:0] mq[$];
    logic       m_ovf;
    logic       m_in_pfx, m_ext, m_brk, m_got;
    int         m_last;

    function automatic logic hk(input logic [7:0] b);
        return b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    endfunction

    function automatic logic [7:0] m_status();
        logic [9:0] h;
        h = (mq.size() != 0) ? mq[0] : 10'd0;
        return {h[9], h[8], m_ovf, (mq.size() == DEPTH), 4'(mq.size())};
    endfunction

    function automatic logic [7:0] pick_byte();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1: return 8'hE0;
            2:    return 8'hF0;
            3: begin
                logic [7:0] hkl [6];
                hkl = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
                return hkl[$urandom_range(0, 5)];
            end
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        logic [7:0] v;

        vecs[0]  = '{8'h1C, 8'h00, 8'h00, 1, 8'h01, 8'h1C};
        vecs[1]  = '{8'hE0, 8'hF0, 8'h75, 3, 8'hC1, 8'h75};
        vecs[2]  = '{8'hFA, 8'h00, 8'h00, 1, 8'h00, 8'h00};
        vecs[3]  = '{8'hAA, 8'h00, 8'h00, 1, 8'h00, 8'h00};
        vecs[4]  = '{8'hF0, 8'hAA, 8'h00, 2, 8'h41, 8'hAA};
        vecs[5]  = '{8'hE0, 8'h74, 8'h00, 2, 8'h81, 8'h74};
        vecs[6]  = '{8'hE0, 8'hE0, 8'h12, 3, 8'h81, 8'h12};
        vecs[7]  = '{8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00};
        vecs[8]  = '{8'hFF, 8'h00, 8'h00, 1, 8'h00, 8'h00};
        vecs[9]  = '{8'hE0, 8'hF0, 8'hE0, 3, 8'hC1, 8'hE0};
        vecs[10] = '{8'hF0, 8'hF0, 8'h00, 2, 8'h41, 8'hF0};
        vecs[11] = '{8'hEE, 8'hFE, 8'h5A, 3, 8'h01, 8'h5A};

        // ---------------- reset state ----------------
        do_reset();
        @(negedge cpuclk);
        chk("reset_intr", {7'd0, intr_out}, 8'h00);
        chk_hiz("reset_hiz", DA, 1'b0);
        rd(SA, v); chk("reset_status", v, 8'h00);
        rd(DA, v); chk("reset_data", v, 8'h00);

        // ---------------- table vectors ----------------
        for (int i = 0; i < 12; i++) begin
            logic [7:0] bs [3];
            do_reset();
            bs = '{vecs[i].b0, vecs[i].b1, vecs[i].b2};
            for (int k = 0; k < vecs[i].n; k++) send_byte(bs[k]);
            rd(SA, v); chk($sformatf("vec%0d_status", i), v, vecs[i].exp_stat);
            rd(DA, v); chk($sformatf("vec%0d_data", i), v, vecs[i].exp_code);
            rd(SA, v); chk($sformatf("vec%0d_after", i), v, 8'h00);
            chk($sformatf("vec%0d_intr", i), {7'd0, intr_out}, 8'h00);
        end

        // ---------------- event latency / interrupt ----------------
        do_reset();
        send_byte(8'h1C);
        chk("evt_intr_rise", {7'd0, intr_out}, 8'h01);
        @(negedge cpuclk);
        ncs = 1'b0; nrd = 1'b0; addr = DA;
        #1 chk("evt_data", data, 8'h1C);
        @(negedge cpuclk);
        ncs = 1'b1; nrd = 1'b1;
        #1 chk("evt_intr_hold", {7'd0, intr_out}, 8'h01);
        @(negedge cpuclk);
        chk("evt_intr_fall", {7'd0, intr_out}, 8'h00);

        // ---------------- overflow ----------------
        do_reset();
        for (int i = 1; i <= 9; i++) send_byte(8'(i));
        rd(SA, v); chk("ovf_status", v, 8'h38);
        for (int i = 1; i <= 8; i++) begin
            rd(DA, v); chk($sformatf("ovf_data%0d", i), v, 8'(i));
        end
        rd(SA, v); chk("ovf_empty_status", v, 8'h20);
        rd(DA, v); chk("ovf_empty_data", v, 8'h00);
        wr_status(8'hDF);
        rd(SA, v); chk("ovf_clear_bit5_only", v, 8'h20);
        wr_status(8'h20);
        rd(SA, v); chk("ovf_cleared", v, 8'h00);

        // ---------------- prefix timeout ----------------
        do_reset();
        send_byte(8'hE0);
        repeat (T + 5) @(negedge cpuclk);
        send_byte(8'h1C);
        rd(SA, v); chk("tmo_status", v, 8'h01);
        rd(DA, v); chk("tmo_data", v, 8'h1C);
        send_byte(8'hE0);
        repeat (T - 8) @(negedge cpuclk);
        send_byte(8'h1C);
        rd(SA, v); chk("notmo_status", v, 8'h81);

        // ---------------- push and pop in the same cycle ----------------
        do_reset();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        @(negedge cpuclk);
        ncs = 1'b0; nrd = 1'b0; addr = DA;
        #1 chk("pp_head", data, 8'h11);
        @(negedge cpuclk);
        ncs = 1'b1; nrd = 1'b1; rx_byte = 8'h44; rx_strobe = 1'b1;
        @(negedge cpuclk);
        rx_strobe = 1'b0;
        rd(SA, v); chk("pp_count", v, 8'h03);
        rd(DA, v); chk("pp_d0", v, 8'h22);
        rd(DA, v); chk("pp_d1", v, 8'h33);
        rd(DA, v); chk("pp_d2", v, 8'h44);

        // ---------------- long read pops once, status never pops ----------------
        do_reset();
        send_byte(8'h55); send_byte(8'h66);
        rd(SA, v); rd(SA, v); chk("stat_nopop", v, 8'h02);
        @(negedge cpuclk);
        ncs = 1'b0; nrd = 1'b0; addr = DA;
        repeat (10) @(negedge cpuclk);
        #1 chk("long_rd_stable", data, 8'h55);
        @(negedge cpuclk);
        ncs = 1'b1; nrd = 1'b1;
        @(negedge cpuclk);
        rd(SA, v); chk("long_rd_once", v, 8'h01);
        rd(DA, v); chk("long_rd_next", v, 8'h66);

        // ---------------- other address, reset with entries queued ----------------
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(8'h20 + 8'(i));
        chk_hiz("other_addr_hiz", 4'd5, 1'b1);
        rd(SA, v); chk("q5_status", v, 8'h05);
        send_byte(8'hE0);
        do_reset();
        @(negedge cpuclk);
        chk("rst_mid_intr", {7'd0, intr_out}, 8'h00);
        chk_hiz("rst_mid_hiz", DA, 1'b0);
        rd(SA, v); chk("rst_mid_status", v, 8'h00);
        send_byte(8'h1C);
        rd(SA, v); chk("rst_mid_nopfx", v, 8'h01);

        // ---------------- randomized run against the model ----------------
        do_reset();
        mq.delete();
        m_ovf = 1'b0; m_in_pfx = 1'b0; m_ext = 1'b0; m_brk = 1'b0; m_got = 1'b0;
        m_last = 0;
        begin
            int         next_strobe = 0;
            int         rd_left = 0;
            logic [3:0] rd_addr = DA;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                logic       stb, rdv_d, rdv_s, wrc, pop, have_ev;
                logic [7:0] b;
                logic [9:0] ev;
                int         slow;
                @(negedge cpuclk);
                slow = (cyc / 600) % 2;
                stb = 1'b0; b = 8'h00; wrc = 1'b0;
                if (cyc >= next_strobe) begin
                    stb = 1'b1; b = pick_byte();
                    next_strobe = cyc + (($urandom_range(0, 15) == 0) ?
                                  T + 8 + int'($urandom_range(0, 5)) :
                                  int'($urandom_range(2, 6)));
                end
                if (rd_left > 0) begin
                    rd_left--;
                end else if ($urandom_range(0, slow ? 30 : 3) == 0) begin
                    rd_addr = ($urandom_range(0, 3) == 0) ? SA : DA;
                    rd_left = int'($urandom_range(1, 3));
                end
                if (rd_left == 0 && $urandom_range(0, 60) == 0) wrc = 1'b1;
                rx_strobe = stb; rx_byte = b;
                ncs = !(rd_left > 0 || wrc);
                nrd = !(rd_left > 0);
                nwr = !wrc;
                addr = wrc ? SA : rd_addr;
                tb_drive = wrc; tb_dout = 8'h20;
                rdv_d = (rd_left > 0) && (rd_addr == DA);
                rdv_s = (rd_left > 0) && (rd_addr == SA);
                #1;
                chk("rnd_intr", {7'd0, intr_out}, {7'd0, mq.size() != 0});
                if (rdv_s) chk("rnd_status", data, m_status());
                if (rdv_d) chk("rnd_data", data, (mq.size() != 0) ? mq[0][7:0] : 8'h00);

                // model: effect of the coming clock edge
                pop   = m_got && !rdv_d && (mq.size() != 0);
                m_got = rdv_d;
                have_ev = 1'b0; ev = 10'd0;
                if (stb) begin
                    if (m_in_pfx && (cyc - m_last) >= T + 2) m_in_pfx = 1'b0;
                    if (!m_in_pfx) begin
                        if (b == 8'hE0)      begin m_in_pfx = 1'b1; m_ext = 1'b1; m_brk = 1'b0; end
                        else if (b == 8'hF0) begin m_in_pfx = 1'b1; m_ext = 1'b0; m_brk = 1'b1; end
                        else if (!hk(b))     begin have_ev = 1'b1; ev = {2'b00, b}; end
                    end else if (m_ext && !m_brk) begin
                        if (b == 8'hF0)      m_brk = 1'b1;
                        else if (b != 8'hE0) begin have_ev = 1'b1; ev = {2'b10, b}; m_in_pfx = 1'b0; end
                    end else begin
                        have_ev = 1'b1; ev = {m_ext, m_brk, b}; m_in_pfx = 1'b0;
                    end
                    m_last = cyc;
                end
                if (pop) void'(mq.pop_front());
                if (wrc) m_ovf = 1'b0;
                if (have_ev) begin
                    if (mq.size() < DEPTH) mq.push_back(ev);
                    else                   m_ovf = 1'b1;
                end
            end
        end
        @(negedge cpuclk);
        ncs = 1'b1; nrd = 1'b1; nwr = 1'b1; rx_strobe = 1'b0; tb_drive = 1'b0;
        @(negedge cpuclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
